// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin sharing of one ALU among NUM_REQ requesters.
// An in-order tag FIFO routes each ALU result back to the requester that
// issued it. FLUSH drains all outstanding operations and then pulses FLUSH_DONE.
// Optional build macro ALU_ARB_STATS_EN adds per-requester issue counters
// and a stall counter (ISSUE_CNT, STALL_CNT).
module alu_req_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_OUTST  = 4
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic [NUM_REQ-1:0]               REQ,
    input  logic [4*NUM_REQ-1:0]             REQ_OP,
    input  logic [2*NUM_REQ-1:0]             REQ_MOVI,
    input  logic [DATA_WIDTH*NUM_REQ-1:0]    REQ_A,
    input  logic [DATA_WIDTH*NUM_REQ-1:0]    REQ_B,
    input  logic [DATA_WIDTH*NUM_REQ-1:0]    REQ_IMM,
    input  logic [DATA_WIDTH*NUM_REQ-1:0]    REQ_MEM,
    output logic [NUM_REQ-1:0]               GNT,
    output logic [NUM_REQ-1:0]               RES_VLD,
    output logic [DATA_WIDTH-1:0]            RES_DATA,
    output logic                             ACT,
    output logic [3:0]                       OP,
    output logic [1:0]                       MOVI,
    output logic [DATA_WIDTH-1:0]            REG_A,
    output logic [DATA_WIDTH-1:0]            REG_B,
    output logic [DATA_WIDTH-1:0]            IMM,
    output logic [DATA_WIDTH-1:0]            MEM,
    input  logic                             ALU_RDY,
    input  logic [DATA_WIDTH-1:0]            EX_ALU,
    input  logic                             EX_ALU_VLD,
    input  logic                             FLUSH,
    output logic                             FLUSH_DONE,
    output logic [$clog2(MAX_OUTST):0]       OUTST,
    output logic                             ERR
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [16*NUM_REQ-1:0]            ISSUE_CNT,
    output logic [15:0]                      STALL_CNT
`endif
);

    localparam int unsigned NR = NUM_REQ;
    localparam int PW = $clog2(NUM_REQ);
    localparam int FW = $clog2(MAX_OUTST);
    localparam int OW = FW + 1;

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE, S_HOLD} state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           ptr_q, ptr_d;
    logic [PW-1:0]           winner, idx;
    logic                    found;
    logic                    full, empty, issue, push, pop, spurious;
    logic [OW-1:0]           outst_q, outst_d;
    logic [FW-1:0]           wr_q, rd_q;
    logic [PW-1:0]           tag_q [MAX_OUTST];
    logic [NUM_REQ-1:0]      res_vld_q;
    logic [DATA_WIDTH-1:0]   res_data_q;
    logic                    err_q;
    logic [3:0]              op_q;
    logic [1:0]              movi_q;
    logic [DATA_WIDTH-1:0]   a_q, b_q, imm_q, mem_q;

    logic [3:0]              op_arr   [NUM_REQ];
    logic [1:0]              movi_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0]   a_arr    [NUM_REQ];
    logic [DATA_WIDTH-1:0]   b_arr    [NUM_REQ];
    logic [DATA_WIDTH-1:0]   imm_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]   mem_arr  [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign op_arr[i]   = REQ_OP[4*i +: 4];
        assign movi_arr[i] = REQ_MOVI[2*i +: 2];
        assign a_arr[i]    = REQ_A[DATA_WIDTH*i +: DATA_WIDTH];
        assign b_arr[i]    = REQ_B[DATA_WIDTH*i +: DATA_WIDTH];
        assign imm_arr[i]  = REQ_IMM[DATA_WIDTH*i +: DATA_WIDTH];
        assign mem_arr[i]  = REQ_MEM[DATA_WIDTH*i +: DATA_WIDTH];
    end

    assign full     = (outst_q == OW'(MAX_OUTST));
    assign empty    = (outst_q == '0);
    // A pop in this cycle does not free a slot: full is taken from the register.
    assign issue    = RST & (state_q == S_RUN) & (|REQ) & ALU_RDY & ~full;
    assign push     = issue;
    assign pop      = RST & EX_ALU_VLD & ~empty;
    assign spurious = EX_ALU_VLD & empty;

    // Round-robin search: first active requester at or above the pointer, wrapping.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned k = 0; k < NR; k++) begin
            idx = PW'((32'(ptr_q) + k) % NR);
            if (!found && REQ[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // Pointer advance and outstanding-count update.
    always_comb begin
        ptr_d   = ptr_q;
        outst_d = outst_q;
        if (issue) begin
            ptr_d = (winner == PW'(NR - 1)) ? '0 : winner + 1'b1;
        end
        case ({push, pop})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase
    end

    // Flush sequencing: RUN -> DRAIN -> DONE -> RUN (or HOLD while FLUSH stays high).
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:   if (FLUSH) state_d = S_DRAIN;
            S_DRAIN: if (outst_q == '0) state_d = S_DONE;
            S_DONE:  state_d = FLUSH ? S_HOLD : S_RUN;
            S_HOLD:  if (!FLUSH) state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    // Control state, FIFO pointers, result and error registers.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= S_RUN;
            ptr_q      <= '0;
            outst_q    <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            res_vld_q  <= '0;
            res_data_q <= '0;
            err_q      <= 1'b0;
            op_q       <= '0;
            movi_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            imm_q      <= '0;
            mem_q      <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            outst_q   <= outst_d;
            res_vld_q <= '0;
            if (push) begin
                wr_q   <= wr_q + 1'b1;
                op_q   <= op_arr[winner];
                movi_q <= movi_arr[winner];
                a_q    <= a_arr[winner];
                b_q    <= b_arr[winner];
                imm_q  <= imm_arr[winner];
                mem_q  <= mem_arr[winner];
            end
            if (pop) begin
                rd_q       <= rd_q + 1'b1;
                res_vld_q  <= NUM_REQ'(1) << tag_q[rd_q];
                res_data_q <= EX_ALU;
            end
            if (spurious) err_q <= 1'b1;
        end
    end

    // Tag storage; contents are meaningless while the count says empty.
    always_ff @(posedge CLK) begin
        if (push) tag_q[wr_q] <= winner;
    end

    assign GNT        = issue ? (NUM_REQ'(1) << winner) : '0;
    assign ACT        = issue;
    assign OP         = issue ? op_arr[winner]   : op_q;
    assign MOVI       = issue ? movi_arr[winner] : movi_q;
    assign REG_A      = issue ? a_arr[winner]    : a_q;
    assign REG_B      = issue ? b_arr[winner]    : b_q;
    assign IMM        = issue ? imm_arr[winner]  : imm_q;
    assign MEM        = issue ? mem_arr[winner]  : mem_q;
    assign RES_VLD    = res_vld_q;
    assign RES_DATA   = res_data_q;
    assign FLUSH_DONE = (state_q == S_DONE);
    assign OUTST      = outst_q;
    assign ERR        = err_q;

`ifdef ALU_ARB_STATS_EN
    logic        stall;
    logic [15:0] stall_cnt_q;

    assign stall = (state_q == S_RUN) & (|REQ) & ~issue;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
        logic [15:0] cnt_q;
        // Saturating count of grants to requester i.
        always_ff @(posedge CLK) begin
            if (!RST) begin
                cnt_q <= '0;
            end else if (issue && (winner == PW'(i)) && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
        assign ISSUE_CNT[16*i +: 16] = cnt_q;
    end

    // Saturating count of RUN cycles where someone requested but nothing issued.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign STALL_CNT = stall_cnt_q;
`endif

endmodule
